tt_seq_mult_display: RTL and testbench

- Parametrised successor to the key/pulse/two-digit display datapath.
- Captures two unsigned operands from the key inputs on successive button pulses and multiplies them with a sequential shift-add engine.
- Drives a paged two-digit hex 7-segment display showing operands, product nibbles or FSM status.
- Sits between the input pins (key, button, page switches) and the 14-bit segment pin bus.

---
 rtl/tt_seq_mult_display.sv | 188 ++++++++++++++++++
 tb/tb_tt_seq_mult_display.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/tt_seq_mult_display.sv
// Two-operand sequential shift-add multiplier driven by a synchronised button,
// with a paged two-digit hex 7-segment display of operands, product or status.
module tt_seq_mult_display #(
    parameter int OP_W        = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 pulse,
    input  logic [OP_W-1:0]      key,
    input  logic [1:0]           page,
    output logic                 busy,
    output logic                 done,
    output logic [2*OP_W-1:0]    product,
    output logic [13:0]          disp_out,
    output logic [1:0]           dbg_state
);

    localparam int PW = 2 * OP_W;
    localparam logic [3:0] LAST_STEP = 4'(OP_W - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT_B = 2'd1,
        S_CALC   = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    // Reset asserts asynchronously but is released on a clock edge.
    logic [1:0] rst_pipe;
    logic       rst_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_pipe <= '0;
        end else begin
            rst_pipe <= {rst_pipe[0], 1'b1};
        end
    end

    assign rst_i = rst_pipe[1];

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_dly;
    logic                   enter;

    always_ff @(posedge clk or negedge rst_i) begin
        if (!rst_i) begin
            sync_q   <= '0;
            sync_dly <= 1'b0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], pulse};
            sync_dly <= sync_q[SYNC_STAGES-1];
        end
    end

    // One enter per rising edge of the synchronised button, however long it is held.
    assign enter = sync_q[SYNC_STAGES-1] & ~sync_dly;

    state_t           state;
    logic [OP_W-1:0]  a_q;
    logic [OP_W-1:0]  b_q;
    logic [PW-1:0]    acc_q;
    logic [3:0]       count_q;

    logic [OP_W-1:0]  b_shift;
    logic [PW-1:0]    addend;
    logic [PW-1:0]    acc_next;

    always_comb begin
        b_shift  = b_q >> count_q;
        addend   = b_shift[0] ? (PW'(a_q) << count_q) : '0;
        acc_next = acc_q + addend;
    end

    always_ff @(posedge clk or negedge rst_i) begin
        if (!rst_i) begin
            state   <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            count_q <= '0;
            product <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (enter) begin
                        a_q     <= key;
                        product <= '0;
                        state   <= S_WAIT_B;
                    end
                end
                S_WAIT_B: begin
                    if (enter) begin
                        b_q     <= key;
                        acc_q   <= '0;
                        count_q <= '0;
                        busy    <= 1'b1;
                        state   <= S_CALC;
                    end
                end
                S_CALC: begin
                    // Button events arriving here are dropped, not queued.
                    acc_q   <= acc_next;
                    count_q <= count_q + 4'd1;
                    if (count_q == LAST_STEP) begin
                        product <= acc_next;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state   <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (enter) begin
                        a_q     <= key;
                        product <= '0;
                        done    <= 1'b0;
                        state   <= S_WAIT_B;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign dbg_state = state;

    function automatic logic [6:0] hex_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'h3F;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5B;
            4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6D;
            4'h6: seg = 7'h7D;
            4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h6F;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;
            4'hD: seg = 7'h5E;
            4'hE: seg = 7'h79;
            default: seg = 7'h71;
        endcase
        return seg;
    endfunction

    // Zero-extend so nibbles beyond the product width read as 0.
    logic [15:0] prod_ext;
    logic [3:0]  upper_nib;
    logic [3:0]  lower_nib;

    assign prod_ext = 16'(product);

    always_comb begin
        upper_nib = 4'h0;
        lower_nib = 4'h0;
        case (page)
            2'd0: begin
                upper_nib = a_q[3:0];
                lower_nib = b_q[3:0];
            end
            2'd1: begin
                upper_nib = prod_ext[7:4];
                lower_nib = prod_ext[3:0];
            end
            2'd2: begin
                upper_nib = prod_ext[15:12];
                lower_nib = prod_ext[11:8];
            end
            default: begin
                upper_nib = {2'b00, state};
                lower_nib = count_q;
            end
        endcase
        disp_out = {hex_seg(upper_nib), hex_seg(lower_nib)};
    end

endmodule

// File: tb/tb_tt_seq_mult_display.sv
// Directed bench for tt_seq_mult_display: a 4-bit and an 8-bit instance share
// clock, reset, button and page; expected values are hand-computed constants.
module tb_tt_seq_mult_display;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pulse;
    logic [1:0]  page;
    logic [3:0]  key4;
    logic [7:0]  key8;
    logic        sel8;

    logic        busy4, done4, busy8, done8;
    logic [7:0]  prod4;
    logic [15:0] prod8;
    logic [13:0] disp4, disp8;
    logic [1:0]  dbg4, dbg8;

    logic        obs_busy, obs_done;
    logic [15:0] obs_prod;
    logic [13:0] obs_disp;

    int n_checks = 0;
    int n_pass   = 0;

    tt_seq_mult_display #(.OP_W(4), .SYNC_STAGES(2)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .pulse(pulse), .key(key4), .page(page),
        .busy(busy4), .done(done4), .product(prod4), .disp_out(disp4),
        .dbg_state(dbg4)
    );

    tt_seq_mult_display #(.OP_W(8), .SYNC_STAGES(2)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .pulse(pulse), .key(key8), .page(page),
        .busy(busy8), .done(done8), .product(prod8), .disp_out(disp8),
        .dbg_state(dbg8)
    );

    // Clock / reset block
    always #5 clk = ~clk;

    assign obs_busy = sel8 ? busy8 : busy4;
    assign obs_done = sel8 ? done8 : done4;
    assign obs_prod = sel8 ? prod8 : {8'h00, prod4};
    assign obs_disp = sel8 ? disp8 : disp4;

    initial begin
        #500000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got %h exp %h", tag, got, exp);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        pulse = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic set_key(input logic [7:0] k);
        key4 = k[3:0];
        key8 = k;
    endtask

    task automatic press(input logic [7:0] k);
        set_key(k);
        pulse = 1'b1;
        repeat (4) @(negedge clk);
        pulse = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic show(input logic [1:0] p);
        page = p;
        #1;
    endtask

    // Enter operand B and watch busy/done; glitch adds an extra edge in CALC
    // and leaves the button held high afterwards.
    task automatic enter_b(input logic [7:0] k, input bit glitch,
                           output int busy_n, output int done_at, output bit overlap);
        set_key(k);
        pulse   = 1'b1;
        busy_n  = 0;
        done_at = -1;
        overlap = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (glitch) begin
                if (i == 2) pulse = 1'b0;
                if (i == 3) begin
                    pulse = 1'b1;
                    set_key(8'h99);
                end
            end else if (i == 3) begin
                pulse = 1'b0;
            end
            if (obs_busy && obs_done) overlap = 1'b1;
            if (obs_busy) busy_n++;
            if (obs_done) begin
                done_at = i;
                break;
            end
        end
    endtask

    int busy_n, done_at;
    bit overlap;

    initial begin
        rst_n = 1'b0;
        pulse = 1'b0;
        page  = 2'd0;
        sel8  = 1'b0;
        set_key(8'h00);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_busy", 32'(busy4), 32'd0);
        check("rst_done", 32'(done4), 32'd0);
        check("rst_prod", 32'(prod4), 32'd0);
        check("rst_disp4", 32'(disp4), 32'h1FBF);
        check("rst_disp8", 32'(disp8), 32'h1FBF);
        check("rst_state", 32'(dbg4), 32'd0);

        // 3 x 5
        press(8'h03);
        show(2'd3);
        check("t1_waitb_digit", 32'(obs_disp[13:7]), 32'h06);
        enter_b(8'h05, 1'b0, busy_n, done_at, overlap);
        check("t1_busy_cycles", 32'(busy_n), 32'd4);
        check("t1_done_latency", 32'(done_at), 32'd6);
        check("t1_no_overlap", 32'(overlap), 32'd0);
        check("t1_prod", 32'(obs_prod), 32'h0F);
        check("t1_state", 32'(dbg4), 32'd3);
        show(2'd1);
        check("t1_page1", 32'(obs_disp), 32'({7'h3F, 7'h71}));
        show(2'd0);
        check("t1_page0", 32'(obs_disp), 32'({7'h4F, 7'h6D}));

        // F x F, started straight from DONE
        press(8'h0F);
        check("t2_done_clear", 32'(obs_done), 32'd0);
        enter_b(8'h0F, 1'b0, busy_n, done_at, overlap);
        check("t2_busy_cycles", 32'(busy_n), 32'd4);
        check("t2_prod", 32'(obs_prod), 32'hE1);
        show(2'd1);
        check("t2_page1", 32'(obs_disp), 32'({7'h79, 7'h06}));
        show(2'd2);
        check("t2_page2", 32'(obs_disp), 32'({7'h3F, 7'h3F}));

        // 0 x 9
        press(8'h00);
        enter_b(8'h09, 1'b0, busy_n, done_at, overlap);
        check("t6_busy_cycles", 32'(busy_n), 32'd4);
        check("t6_done", 32'(obs_done), 32'd1);
        check("t6_prod", 32'(obs_prod), 32'h00);
        show(2'd3);
        check("t6_page3", 32'(obs_disp), 32'({7'h4F, 7'h66}));

        // 7 x 2 with an extra edge during CALC and a long hold
        do_reset();
        press(8'h07);
        enter_b(8'h02, 1'b1, busy_n, done_at, overlap);
        check("t4_busy_cycles", 32'(busy_n), 32'd4);
        repeat (44) @(negedge clk);
        check("t4_done_held", 32'(obs_done), 32'd1);
        check("t4_prod", 32'(obs_prod), 32'h0E);
        show(2'd1);
        check("t4_page1", 32'(obs_disp), 32'({7'h3F, 7'h79}));
        pulse = 1'b0;
        repeat (3) @(negedge clk);
        press(8'h00);
        check("t4_restart_prod", 32'(obs_prod), 32'h00);
        check("t4_restart_done", 32'(obs_done), 32'd0);
        show(2'd3);
        check("t4_restart_state", 32'(obs_disp[13:7]), 32'h06);
        show(2'd0);
        check("t4_restart_page0", 32'(obs_disp), 32'({7'h3F, 7'h5B}));

        // Reset during the second CALC cycle
        do_reset();
        press(8'h03);
        set_key(8'h05);
        pulse = 1'b1;
        repeat (4) @(negedge clk);
        check("t5_busy_before", 32'(obs_busy), 32'd1);
        rst_n = 1'b0;
        pulse = 1'b0;
        #1;
        check("t5_busy", 32'(obs_busy), 32'd0);
        check("t5_done", 32'(obs_done), 32'd0);
        check("t5_prod", 32'(obs_prod), 32'd0);
        check("t5_disp", 32'(obs_disp), 32'h1FBF);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        press(8'h06);
        show(2'd3);
        check("t5_after_state", 32'(obs_disp), 32'({7'h06, 7'h3F}));
        show(2'd0);
        check("t5_after_a", 32'(obs_disp[13:7]), 32'h7D);

        // 8-bit instance: FF x FF
        do_reset();
        sel8 = 1'b1;
        press(8'hFF);
        enter_b(8'hFF, 1'b0, busy_n, done_at, overlap);
        check("t3_busy_cycles", 32'(busy_n), 32'd8);
        check("t3_done_latency", 32'(done_at), 32'd10);
        check("t3_prod", 32'(obs_prod), 32'hFE01);
        show(2'd2);
        check("t3_page2", 32'(obs_disp), 32'({7'h71, 7'h79}));
        show(2'd1);
        check("t3_page1", 32'(obs_disp), 32'({7'h3F, 7'h06}));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
